// File: rtl/score_bcd_display.sv
// score_bcd_display: converts the binary pellet score to packed BCD using a
// sequential double-dabble engine (one add-3/shift iteration per clock) and
// drives active-low gfedcba seven-segment patterns for the HEX displays.
// A new conversion starts automatically whenever score_in differs from the
// last converted value. bcd_out and hex_out hold their previous values until
// the final iteration commits both on the same edge, together with a
// one-cycle done pulse.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks hex digits above the
// most-significant nonzero digit; digit 0 is always shown.
module score_bcd_display #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      score_in,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic [DIGITS*7-1:0]   hex_out,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = DIGITS * 4;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Active-low gfedcba glyph for one BCD digit; non-BCD codes show blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Display pattern shown after reset, i.e. the rendering of score 0.
    function automatic logic [DIGITS*7-1:0] reset_hex();
        logic [DIGITS*7-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            r[i*7 +: 7] = (i == 0) ? 7'h40 : 7'h7F;
`else
            r[i*7 +: 7] = 7'h40;
`endif
        end
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    last_q, last_d;
    logic [SW-1:0]       shreg_q, shreg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [DIGITS*7-1:0] hex_q, hex_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [SW-1:0]       adj;
    logic [SW-1:0]       shifted;
    logic [BW-1:0]       bcd_new;
    logic [DIGITS*7-1:0] hex_new;
`ifdef LEADING_ZERO_BLANK_EN
    logic                seen_nz;
`endif

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
    always_comb begin
        adj = shreg_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[WIDTH + i*4 +: 4] >= 4'd5) begin
                adj[WIDTH + i*4 +: 4] = adj[WIDTH + i*4 +: 4] + 4'd3;
            end
        end
        shifted = {adj[SW-2:0], 1'b0};
        bcd_new = shifted[SW-1 -: BW];
    end

    // Segment patterns for the BCD value being committed this iteration.
    always_comb begin
        hex_new = '0;
`ifdef LEADING_ZERO_BLANK_EN
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if ((bcd_new[i*4 +: 4] != 4'd0) || (i == 0)) begin
                seen_nz = 1'b1;
            end
            hex_new[i*7 +: 7] = seen_nz ? seg7(bcd_new[i*4 +: 4]) : 7'h7F;
        end
`else
        for (int i = 0; i < DIGITS; i++) begin
            hex_new[i*7 +: 7] = seg7(bcd_new[i*4 +: 4]);
        end
`endif
    end

    // Next-state logic: detect score change in IDLE, iterate in SHIFT, commit.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (score_in != last_q) begin
                    shreg_d = {{BW{1'b0}}, score_in};
                    cnt_d   = '0;
                    last_d  = score_in;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    bcd_d   = bcd_new;
                    hex_d   = hex_new;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            hex_q   <= reset_hex();
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bcd_out = bcd_q;
    assign hex_out = hex_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed testbench for score_bcd_display (default parameters). Expected
// BCD and segment values are hand-computed; display expectations follow the
// LEADING_ZERO_BLANK_EN build macro so the bench suits either build.
module tb_score_bcd_display;

  logic        clk;
  logic        reset;
  logic [11:0] score_in;
  logic [15:0] bcd_out;
  logic [27:0] hex_out;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_count = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [27:0] HEX_RST = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
  localparam logic [27:0] HEX_RST = {7'h40, 7'h40, 7'h40, 7'h40};
`endif

  score_bcd_display #(.WIDTH(12), .DIGITS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .score_in (score_in),
    .bcd_out  (bcd_out),
    .hex_out  (hex_out),
    .busy     (busy),
    .done     (done)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // done is high for one full cycle per pulse, so one negedge sample each
  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
  end

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // edges until done is seen (returns -1 when the budget runs out)
  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (cycles < limit) begin
      tick();
      cycles++;
      if (done === 1'b1) return;
    end
    cycles = -1;
  endtask

  task automatic test_reset();
    int c0;
    reset = 1'b1;
    score_in = 12'd0;
    ticks(3);
    reset = 1'b0;
    c0 = done_count;
    ticks(50);
    n_checks++;
    if (bcd_out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_bcd got %h want %h", bcd_out, 16'h0000);
    end
    n_checks++;
    if (hex_out !== HEX_RST) begin
      n_fail++; $display("FAIL reset_hex got %h want %h", hex_out, HEX_RST);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b want 0", busy);
    end
    n_checks++;
    if (done_count - c0 != 0) begin
      n_fail++; $display("FAIL reset_no_done got %0d pulses want 0", done_count - c0);
    end
  endtask

  task automatic test_single();
    int c0, cyc;
    c0 = done_count;
    score_in = 12'd1;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL single_busy_start got %b want 1", busy);
    end
    ticks(5);
    n_checks++;
    if (bcd_out !== 16'h0000) begin
      n_fail++; $display("FAIL single_hold got %h want %h", bcd_out, 16'h0000);
    end
    wait_done(20, cyc);
    n_checks++;
    if (cyc !== 7) begin
      n_fail++; $display("FAIL single_latency got %0d more edges want 7 (13 total)", cyc);
    end
    n_checks++;
    if (bcd_out !== 16'h0001) begin
      n_fail++; $display("FAIL single_bcd got %h want %h", bcd_out, 16'h0001);
    end
    n_checks++;
    if (hex_out[6:0] !== 7'h79) begin
      n_fail++; $display("FAIL single_hex0 got %h want %h", hex_out[6:0], 7'h79);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL single_busy_end got %b want 0", busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL single_done_width got %b want 0", done);
    end
    n_checks++;
    if (done_count - c0 != 1) begin
      n_fail++; $display("FAIL single_done_count got %0d want 1", done_count - c0);
    end
  endtask

  task automatic test_values();
    int cyc;
    logic [27:0] exp_hex;
    score_in = 12'h1DE;
    wait_done(20, cyc);
    n_checks++;
    if (cyc !== 13) begin
      n_fail++; $display("FAIL v478_latency got %0d want 13", cyc);
    end
    n_checks++;
    if (bcd_out !== 16'h0478) begin
      n_fail++; $display("FAIL v478_bcd got %h want %h", bcd_out, 16'h0478);
    end
`ifdef LEADING_ZERO_BLANK_EN
    exp_hex = {7'h7F, 7'h19, 7'h78, 7'h00};
`else
    exp_hex = {7'h40, 7'h19, 7'h78, 7'h00};
`endif
    n_checks++;
    if (hex_out !== exp_hex) begin
      n_fail++; $display("FAIL v478_hex got %h want %h", hex_out, exp_hex);
    end
    tick();
    score_in = 12'hFFF;
    wait_done(20, cyc);
    n_checks++;
    if (bcd_out !== 16'h4095) begin
      n_fail++; $display("FAIL v4095_bcd got %h want %h", bcd_out, 16'h4095);
    end
    exp_hex = {7'h19, 7'h40, 7'h10, 7'h12};
    n_checks++;
    if (hex_out !== exp_hex) begin
      n_fail++; $display("FAIL v4095_hex got %h want %h", hex_out, exp_hex);
    end
  endtask

  task automatic test_back_to_back();
    int c0, cyc;
    tick();
    c0 = done_count;
    score_in = 12'd5;
    ticks(4);
    score_in = 12'd9;
    wait_done(20, cyc);
    n_checks++;
    if (cyc !== 9) begin
      n_fail++; $display("FAIL b2b_first_latency got %0d want 9", cyc);
    end
    n_checks++;
    if (bcd_out !== 16'h0005) begin
      n_fail++; $display("FAIL b2b_first_bcd got %h want %h", bcd_out, 16'h0005);
    end
    wait_done(20, cyc);
    n_checks++;
    if (cyc !== 13) begin
      n_fail++; $display("FAIL b2b_second_latency got %0d want 13", cyc);
    end
    n_checks++;
    if (bcd_out !== 16'h0009) begin
      n_fail++; $display("FAIL b2b_second_bcd got %h want %h", bcd_out, 16'h0009);
    end
    ticks(5);
    n_checks++;
    if (done_count - c0 != 2) begin
      n_fail++; $display("FAIL b2b_done_count got %0d want 2", done_count - c0);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy_idle got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [27:0] exp_hex;
    score_in = 12'd123;
    tick();
    ticks(6);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bcd_out !== 16'h0000) begin
      n_fail++; $display("FAIL midrst_bcd got %h want %h", bcd_out, 16'h0000);
    end
    n_checks++;
    if (hex_out !== HEX_RST) begin
      n_fail++; $display("FAIL midrst_hex got %h want %h", hex_out, HEX_RST);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags got busy=%b done=%b want 0 0", busy, done);
    end
    ticks(2);
    reset = 1'b0;
    wait_done(20, cyc);
    n_checks++;
    if (cyc !== 13) begin
      n_fail++; $display("FAIL midrst_latency got %0d want 13", cyc);
    end
    n_checks++;
    if (bcd_out !== 16'h0123) begin
      n_fail++; $display("FAIL midrst_bcd_after got %h want %h", bcd_out, 16'h0123);
    end
`ifdef LEADING_ZERO_BLANK_EN
    exp_hex = {7'h7F, 7'h79, 7'h24, 7'h30};
`else
    exp_hex = {7'h40, 7'h79, 7'h24, 7'h30};
`endif
    n_checks++;
    if (hex_out !== exp_hex) begin
      n_fail++; $display("FAIL midrst_hex_after got %h want %h", hex_out, exp_hex);
    end
  endtask

  task automatic test_zero_return();
    int cyc;
    tick();
    score_in = 12'd0;
    wait_done(20, cyc);
    n_checks++;
    if (bcd_out !== 16'h0000) begin
      n_fail++; $display("FAIL zero_bcd got %h want %h", bcd_out, 16'h0000);
    end
    n_checks++;
    if (hex_out !== HEX_RST) begin
      n_fail++; $display("FAIL zero_hex got %h want %h", hex_out, HEX_RST);
    end
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_blanking();
    int cyc;
    logic [27:0] exp_hex;
    tick();
    score_in = 12'd7;
    wait_done(20, cyc);
    exp_hex = {7'h7F, 7'h7F, 7'h7F, 7'h78};
    n_checks++;
    if (hex_out !== exp_hex) begin
      n_fail++; $display("FAIL blank7_hex got %h want %h", hex_out, exp_hex);
    end
    tick();
    score_in = 12'd100;
    wait_done(20, cyc);
    exp_hex = {7'h7F, 7'h79, 7'h40, 7'h40};
    n_checks++;
    if (hex_out !== exp_hex) begin
      n_fail++; $display("FAIL blank100_hex got %h want %h", hex_out, exp_hex);
    end
    n_checks++;
    if (bcd_out !== 16'h0100) begin
      n_fail++; $display("FAIL blank100_bcd got %h want %h", bcd_out, 16'h0100);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    score_in = 12'd0;
    test_reset();
    test_single();
    test_values();
    test_back_to_back();
    test_reset_mid();
    test_zero_return();
`ifdef LEADING_ZERO_BLANK_EN
    test_blanking();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_bcd_display.md
Name: score_bcd_display

Overview:
Downstream consumer of the 12-bit pellet score counter. Converts the binary score to packed BCD with a sequential double-dabble engine (one shift per clock). Drives active-low seven-segment patterns for the board HEX displays.
Reconverts automatically whenever the score value changes, so the score logic needs no handshake.

Parameters:
WIDTH, 12, binary score width.
DIGITS, 4, number of BCD digits / displays; must satisfy 10^DIGITS > 2^WIDTH - 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
score_in  input  WIDTH  binary score from the score counter.
bcd_out  output  DIGITS*4  packed BCD; digit 0 (units) in [3:0].
hex_out  output  DIGITS*7  seven-segment patterns, active-low gfedcba; digit 0 in [6:0].
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd_out/hex_out are updated.

Behaviour:
- Reset (async, active-high) values:
  - bcd_out = 0.
  - Every hex_out digit = 7'h40 (glyph "0").
  - busy = 0, done = 0.
  - FSM = IDLE; internal last_value = 0; iteration counter = 0.
- FSM states: IDLE, SHIFT.
- IDLE:
  - Each cycle, compare score_in with last_value.
  - If unequal, on the next edge:
    - Latch score_in into the binary field of the shift register (DIGITS*4 + WIDTH bits).
    - Clear the BCD field, set the counter to 0, and store the latched value in last_value.
    - Go to SHIFT and set busy = 1.
- SHIFT, one iteration per edge:
  - Add 3 to every BCD nibble whose value is >= 5.
  - Then shift the whole register left by 1.
  - Increment the counter.
- Completion:
  - The edge that performs iteration WIDTH (the 12th) also commits bcd_out and hex_out (both registered, updated on the same edge).
  - On that edge: done = 1 for exactly one cycle, busy = 0, state returns to IDLE.
- Latency:
  - score_in change to bcd_out update = WIDTH+1 edges (13 at default).
  - Outputs hold their previous values during conversion.
- score_in changes during SHIFT:
  - Ignored by the running conversion; no restart or abort.
  - Back in IDLE, the compare sees the current score_in and starts a new conversion.
  - Result: the final settled value is always displayed, and intermediate values may be skipped.
- Back-to-back changes: the earliest new conversion latches on the edge after the commit edge (one IDLE cycle minimum).
- Segment map, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any non-BCD nibble shows blank 7F; this is unreachable in normal operation.
- Reset asserted mid-conversion: immediate return to reset values; the partial result is discarded.
- After reset release, no conversion occurs while score_in == 0, because last_value matches.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - At commit, hex_out digits above the most-significant nonzero digit are driven 7'h7F (blank).
  - Digit 0 is always shown; a score of 0 shows only "0" on digit 0.
  - Reset value: digit 0 = 7'h40, other digits = 7'h7F.
  - bcd_out is unaffected.
- Undefined: all DIGITS digits always display, including leading zeros.

Test Plan:
1. Assert reset, release, hold score_in=0 for 50 cycles -> bcd_out=16'h0000, every hex digit 7'h40, busy=0, done never pulses.
2. score_in 0->1 -> busy high for 13 edges; bcd_out=16'h0001, hex_out[6:0]=7'h79, a single done pulse coincident with the update.
3. score_in=12'h1DE (478) -> bcd_out=16'h0478; digit2=7'h19, digit1=7'h78, digit0=7'h00, digit3=7'h40. Then score_in=12'hFFF -> bcd_out=16'h4095.
4. score_in=5, then score_in=9 four cycles later, mid-conversion -> first done with bcd_out=16'h0005; new conversion latches the edge after; second done with bcd_out=16'h0009; exactly two done pulses.
5. score_in=123, assert reset 6 cycles into SHIFT -> outputs return to reset values immediately. Release with score_in still 123 -> conversion restarts, bcd_out=16'h0123 after 13 edges.
6. With LEADING_ZERO_BLANK_EN, score_in=7 -> digits 3..1 = 7'h7F, digit0=7'h78. Then score_in=100 -> digit3=7'h7F, digit2=7'h79, digit1=7'h40, digit0=7'h40.
